// File: rtl/io_request_arbiter_if.sv
// Bundle between requesters, the io_request_arbiter and the shared io_module.
// The arbiter uses the master modport; the surrounding environment uses slave.
interface io_request_arbiter_if #(
  parameter int unsigned REQUESTERS       = 4,
  parameter int unsigned INSTRUCTION_SIZE = 3,
  parameter int unsigned SIZE_WORD        = 5,
  parameter int unsigned AUXILIAR_SIZE    = 44,
  parameter int unsigned IO_OUTPUT_SIZE   = 8
);
  logic [REQUESTERS-1:0]                  req_valid;
  logic [REQUESTERS*INSTRUCTION_SIZE-1:0] req_instr;
  logic [REQUESTERS*SIZE_WORD-1:0]        req_register;
  logic [REQUESTERS*AUXILIAR_SIZE-1:0]    req_aux;
  logic [REQUESTERS-1:0]                  req_ready;
  logic [REQUESTERS-1:0]                  resp_valid;
  logic [IO_OUTPUT_SIZE-1:0]              resp_data;
  logic                                   resp_err;
  logic [INSTRUCTION_SIZE-1:0]            io_instrucction;
  logic [SIZE_WORD-1:0]                   io_register;
  logic [AUXILIAR_SIZE-1:0]               io_auxiliar_register;
  logic                                   io_valid_instrucction;
  logic                                   io_busy;
  logic [IO_OUTPUT_SIZE-1:0]              io_result;
  logic                                   arb_busy;

  modport master (
    input  req_valid, req_instr, req_register, req_aux, io_busy, io_result,
    output req_ready, resp_valid, resp_data, resp_err,
           io_instrucction, io_register, io_auxiliar_register,
           io_valid_instrucction, arb_busy
  );

  modport slave (
    output req_valid, req_instr, req_register, req_aux, io_busy, io_result,
    input  req_ready, resp_valid, resp_data, resp_err,
           io_instrucction, io_register, io_auxiliar_register,
           io_valid_instrucction, arb_busy
  );
endinterface

// File: rtl/io_request_arbiter.sv
// Round-robin arbiter sharing one io_module between several command sources:
// grants, holds the command through the busy window and returns a response.
module io_request_arbiter #(
  parameter int unsigned REQUESTERS       = 4,
  parameter int unsigned INSTRUCTION_SIZE = 3,
  parameter int unsigned SIZE_WORD        = 5,
  parameter int unsigned AUXILIAR_SIZE    = 44,
  parameter int unsigned IO_OUTPUT_SIZE   = 8,
  parameter int unsigned ACK_TIMEOUT      = 3
) (
  input logic              clk,
  input logic              rst,
  io_request_arbiter_if.master bus
);
  localparam int unsigned PTR_W = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
  localparam int unsigned SUM_W = PTR_W + 1;
  localparam int unsigned CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(REQUESTERS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, RUN, RESP} state_t;

  state_t                      state, state_n;
  logic [PTR_W-1:0]            ptr, ptr_n, grant;
  logic                        found;
  logic [CNT_W-1:0]            cnt, cnt_n;
  logic [REQUESTERS-1:0]       req_ready_q, req_ready_n, resp_valid_q, resp_valid_n;
  logic [REQUESTERS-1:0]       grant_1h, ptr_1h;
  logic [IO_OUTPUT_SIZE-1:0]   resp_data_q, resp_data_n;
  logic                        resp_err_q, resp_err_n;
  logic [INSTRUCTION_SIZE-1:0] instr_q, instr_n;
  logic [SIZE_WORD-1:0]        reg_q, reg_n;
  logic [AUXILIAR_SIZE-1:0]    aux_q, aux_n;
  logic                        io_valid_q, io_valid_n, arb_busy_q, arb_busy_n;
  logic                        is_read;

  logic [INSTRUCTION_SIZE-1:0] instr_arr [REQUESTERS];
  logic [SIZE_WORD-1:0]        reg_arr   [REQUESTERS];
  logic [AUXILIAR_SIZE-1:0]    aux_arr   [REQUESTERS];

  // Unpack per-requester operand slices
  for (genvar gi = 0; gi < REQUESTERS; gi++) begin : g_unpack
    assign instr_arr[gi] = bus.req_instr[gi*INSTRUCTION_SIZE +: INSTRUCTION_SIZE];
    assign reg_arr[gi]   = bus.req_register[gi*SIZE_WORD +: SIZE_WORD];
    assign aux_arr[gi]   = bus.req_aux[gi*AUXILIAR_SIZE +: AUXILIAR_SIZE];
  end

  // First pending requester searching upward from ptr+1, with wrap
  always_comb begin
    logic [SUM_W-1:0] sum;
    found = 1'b0;
    grant = ptr;
    sum   = '0;
    for (int unsigned i = 1; i <= REQUESTERS; i++) begin
      sum = {1'b0, ptr} + SUM_W'(i);
      if (sum >= SUM_W'(REQUESTERS)) sum = sum - SUM_W'(REQUESTERS);
      if (!found && bus.req_valid[sum[PTR_W-1:0]]) begin
        found = 1'b1;
        grant = sum[PTR_W-1:0];
      end
    end
  end

  assign grant_1h = REQUESTERS'(1) << grant;
  assign ptr_1h   = REQUESTERS'(1) << ptr;
  assign is_read  = (instr_q == INSTRUCTION_SIZE'(3'b100)) ||
                    (instr_q == INSTRUCTION_SIZE'(3'b101)) ||
                    (instr_q == INSTRUCTION_SIZE'(3'b110));

  // Next state and next values of every registered output
  always_comb begin
    state_n      = state;
    ptr_n        = ptr;
    cnt_n        = cnt;
    req_ready_n  = '0;
    resp_valid_n = '0;
    resp_data_n  = resp_data_q;
    resp_err_n   = resp_err_q;
    instr_n      = instr_q;
    reg_n        = reg_q;
    aux_n        = aux_q;
    io_valid_n   = 1'b0;
    case (state)
      IDLE: begin
        if (found && !bus.io_busy) begin
          state_n     = ISSUE;
          ptr_n       = grant;
          req_ready_n = grant_1h;
          io_valid_n  = 1'b1;
          instr_n     = instr_arr[grant];
          reg_n       = reg_arr[grant];
          aux_n       = aux_arr[grant];
        end
      end
      ISSUE: begin
        state_n = WAIT_BUSY;
        cnt_n   = '0;
      end
      WAIT_BUSY: begin
        if (bus.io_busy) begin
          state_n = RUN;
        end else if (cnt == CNT_LAST) begin
          // io_module never acknowledged: report an error response
          state_n      = RESP;
          resp_valid_n = ptr_1h;
          resp_err_n   = 1'b1;
          resp_data_n  = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      RUN: begin
        if (!bus.io_busy) begin
          state_n      = RESP;
          resp_valid_n = ptr_1h;
          resp_err_n   = 1'b0;
          resp_data_n  = is_read ? bus.io_result : '0;
        end
      end
      RESP: begin
        state_n     = IDLE;
        resp_data_n = '0;
        resp_err_n  = 1'b0;
      end
      default: state_n = IDLE;
    endcase
    arb_busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      ptr          <= PTR_RST;
      cnt          <= '0;
      req_ready_q  <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      instr_q      <= '0;
      reg_q        <= '0;
      aux_q        <= '0;
      io_valid_q   <= 1'b0;
      arb_busy_q   <= 1'b0;
    end else begin
      state        <= state_n;
      ptr          <= ptr_n;
      cnt          <= cnt_n;
      req_ready_q  <= req_ready_n;
      resp_valid_q <= resp_valid_n;
      resp_data_q  <= resp_data_n;
      resp_err_q   <= resp_err_n;
      instr_q      <= instr_n;
      reg_q        <= reg_n;
      aux_q        <= aux_n;
      io_valid_q   <= io_valid_n;
      arb_busy_q   <= arb_busy_n;
    end
  end

  assign bus.req_ready             = req_ready_q;
  assign bus.resp_valid            = resp_valid_q;
  assign bus.resp_data             = resp_data_q;
  assign bus.resp_err              = resp_err_q;
  assign bus.io_instrucction       = instr_q;
  assign bus.io_register           = reg_q;
  assign bus.io_auxiliar_register  = aux_q;
  assign bus.io_valid_instrucction = io_valid_q;
  assign bus.arb_busy              = arb_busy_q;
endmodule

// File: tb/tb_io_request_arbiter.sv
// Directed bench for io_request_arbiter with a small io_module busy model.
module tb_io_request_arbiter;
  localparam int R  = 4;
  localparam int IW = 3;
  localparam int SW = 5;
  localparam int AW = 44;
  localparam int OW = 8;
  localparam int AT = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  io_request_arbiter_if #(.REQUESTERS(R), .INSTRUCTION_SIZE(IW), .SIZE_WORD(SW),
                          .AUXILIAR_SIZE(AW), .IO_OUTPUT_SIZE(OW)) bus ();

  io_request_arbiter #(.REQUESTERS(R), .INSTRUCTION_SIZE(IW), .SIZE_WORD(SW),
                       .AUXILIAR_SIZE(AW), .IO_OUTPUT_SIZE(OW), .ACK_TIMEOUT(AT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int busy_len = 1;
  bit no_ack   = 1'b0;
  int busy_cnt = 0;

  // io_module model: busy for busy_len cycles after each valid instruction
  always @(posedge clk) begin
    if (!rst) busy_cnt <= 0;
    else if (bus.io_valid_instrucction && !no_ack) busy_cnt <= busy_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign bus.io_busy = (busy_cnt > 0);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic set_req(input int i, input logic [IW-1:0] ins, input logic [SW-1:0] rg,
                         input logic [AW-1:0] ax);
    bus.req_instr[i*IW +: IW]    = ins;
    bus.req_register[i*SW +: SW] = rg;
    bus.req_aux[i*AW +: AW]      = ax;
  endtask

  // Returns granted index and how many extra negedges passed before req_ready
  task automatic wait_ready(output int g, output int w);
    g = -1;
    w = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.req_ready != '0) begin
        for (int k = 0; k < R; k++) if (bus.req_ready[k]) g = k;
        w = i;
        check("ready_onehot", 64'($onehot(bus.req_ready)), 64'd1);
        check("io_valid_with_ready", 64'(bus.io_valid_instrucction), 64'd1);
        break;
      end
    end
    if (g < 0) check("ready_seen", 64'(bus.req_ready != '0), 64'd1);
  endtask

  // Negedges from the ready cycle to resp_valid; operands must hold meanwhile
  task automatic wait_resp(input logic [IW-1:0] ei, input logic [SW-1:0] er,
                           input logic [AW-1:0] ea, output int n);
    bit stable = 1'b1;
    int vcnt   = 0;
    n = -1;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (bus.io_instrucction !== ei || bus.io_register !== er ||
          bus.io_auxiliar_register !== ea) stable = 1'b0;
      if (bus.io_valid_instrucction) vcnt++;
      if (bus.resp_valid != '0) begin
        n = i;
        break;
      end
    end
    check("resp_seen", 64'(bus.resp_valid != '0), 64'd1);
    check("io_operands_stable", 64'(stable), 64'd1);
    check("io_valid_single_cycle", 64'(vcnt), 64'd0);
  endtask

  task automatic check_resp(input string tag, input int n, input int exp_n,
                            input int g, input logic [OW-1:0] d, input logic e);
    check({tag, "_latency"}, 64'(n), 64'(exp_n));
    check({tag, "_resp_valid"}, 64'(bus.resp_valid), 64'(1 << g));
    check({tag, "_resp_data"}, 64'(bus.resp_data), 64'(d));
    check({tag, "_resp_err"}, 64'(bus.resp_err), 64'(e));
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    check({tag, "_idle_resp_valid"}, 64'(bus.resp_valid), 64'd0);
    check({tag, "_idle_resp_data"}, 64'(bus.resp_data), 64'd0);
    check({tag, "_idle_arb_busy"}, 64'(bus.arb_busy), 64'd0);
  endtask

  initial begin
    int g, w, n;
    int rr_exp [5] = '{0, 1, 2, 3, 0};
    bit saw_resp;

    bus.req_valid = '0;
    bus.req_instr = '0;
    bus.req_register = '0;
    bus.req_aux = '0;
    bus.io_result = 8'hA5;

    // Reset held with every requester pending
    for (int i = 0; i < R; i++) set_req(i, 3'b011, SW'(10 + i), AW'(256 + i));
    bus.req_valid = '1;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_resp_data", 64'(bus.resp_data), 64'd0);
    check("rst_resp_err", 64'(bus.resp_err), 64'd0);
    check("rst_io_instr", 64'(bus.io_instrucction), 64'd0);
    check("rst_io_register", 64'(bus.io_register), 64'd0);
    check("rst_io_aux", 64'(bus.io_auxiliar_register), 64'd0);
    check("rst_io_valid", 64'(bus.io_valid_instrucction), 64'd0);
    check("rst_arb_busy", 64'(bus.arb_busy), 64'd0);
    rst = 1'b1;

    // Round robin with all requesters continuously valid
    for (int k = 0; k < 5; k++) begin
      wait_ready(g, w);
      check("rr_grant", 64'(g), 64'(rr_exp[k]));
      check("rr_ready_gap", 64'(w), 64'd0);
      check("rr_io_register", 64'(bus.io_register), 64'(10 + rr_exp[k]));
      wait_resp(3'b011, SW'(10 + rr_exp[k]), AW'(256 + rr_exp[k]), n);
      check_resp("rr", n, 3, rr_exp[k], 8'h00, 1'b0);
      if (k == 4) bus.req_valid = '0;
      check_idle("rr");
    end

    // Single read: data captured from io_result
    set_req(0, 3'b110, 5'd7, 44'h123);
    bus.io_result = 8'hA5;
    busy_len = 1;
    bus.req_valid = 4'b0001;
    wait_ready(g, w);
    bus.req_valid = '0;
    check("rd_grant", 64'(g), 64'd0);
    check("rd_ready_latency", 64'(w), 64'd0);
    wait_resp(3'b110, 5'd7, 44'h123, n);
    check_resp("rd", n, 3, 0, 8'hA5, 1'b0);
    check_idle("rd");

    // Long delay: non-read returns zero even with io_result nonzero
    set_req(2, 3'b000, 5'd19, 44'd20);
    busy_len = 20;
    bus.req_valid = 4'b0100;
    wait_ready(g, w);
    bus.req_valid = '0;
    check("dly_grant", 64'(g), 64'd2);
    wait_resp(3'b000, 5'd19, 44'd20, n);
    check_resp("dly", n, 22, 2, 8'h00, 1'b0);
    check_idle("dly");

    // Timeout: io model never acknowledges
    set_req(3, 3'b100, 5'd3, 44'h5A5);
    no_ack = 1'b1;
    bus.req_valid = 4'b1000;
    wait_ready(g, w);
    bus.req_valid = '0;
    check("to_grant", 64'(g), 64'd3);
    wait_resp(3'b100, 5'd3, 44'h5A5, n);
    check_resp("to", n, AT + 1, 3, 8'h00, 1'b1);
    check_idle("to");
    check("to_err_cleared", 64'(bus.resp_err), 64'd0);
    no_ack = 1'b0;

    // Normal operation after a timeout
    set_req(1, 3'b101, 5'd9, 44'h77);
    bus.io_result = 8'h3C;
    busy_len = 2;
    bus.req_valid = 4'b0010;
    wait_ready(g, w);
    bus.req_valid = '0;
    check("rec_grant", 64'(g), 64'd1);
    wait_resp(3'b101, 5'd9, 44'h77, n);
    check_resp("rec", n, 4, 1, 8'h3C, 1'b0);
    check_idle("rec");

    // Reset during RUN abandons the command and resets the pointer
    set_req(1, 3'b000, 5'd21, 44'd10);
    busy_len = 10;
    bus.req_valid = 4'b0010;
    wait_ready(g, w);
    bus.req_valid = '0;
    check("mr_grant", 64'(g), 64'd1);
    repeat (3) @(negedge clk);
    check("mr_busy_before", 64'(bus.arb_busy), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    check("mr_arb_busy", 64'(bus.arb_busy), 64'd0);
    check("mr_io_instr", 64'(bus.io_instrucction), 64'd0);
    check("mr_io_register", 64'(bus.io_register), 64'd0);
    check("mr_io_aux", 64'(bus.io_auxiliar_register), 64'd0);
    rst = 1'b1;
    saw_resp = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.resp_valid != '0 || bus.arb_busy) saw_resp = 1'b1;
    end
    check("mr_no_resp", 64'(saw_resp), 64'd0);
    set_req(0, 3'b011, 5'd1, 44'd1);
    set_req(2, 3'b011, 5'd2, 44'd2);
    busy_len = 1;
    bus.req_valid = 4'b0101;
    wait_ready(g, w);
    bus.req_valid[0] = 1'b0;
    check("mr_first_grant", 64'(g), 64'd0);
    wait_resp(3'b011, 5'd1, 44'd1, n);
    check_resp("mr0", n, 3, 0, 8'h00, 1'b0);
    check_idle("mr0");
    wait_ready(g, w);
    bus.req_valid[2] = 1'b0;
    check("mr_second_grant", 64'(g), 64'd2);
    wait_resp(3'b011, 5'd2, 44'd2, n);
    check_resp("mr2", n, 3, 2, 8'h00, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
